async_fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of the asynchronous FIFO between NUM_REQ requesters. It sits entirely in the write clock domain, and drives the FIFO's w_en/data_in directly from the granted requester. Grants are held for bursts of up to MAX_BURST beats. It honours the FIFO's full flag with zero-cycle backpressure.

---
 rtl/async_fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin write-port arbiter feeding an async FIFO's write side, burst-limited grants.
// Optional per-requester beat counters: define ASYNC_FIFO_WR_ARB_STATS_EN.
module async_fifo_wr_arbiter #(
    parameter int unsigned  NUM_REQ   = 4,
    parameter int unsigned  WIDTH     = 8,
    parameter int unsigned  MAX_BURST = 4,
    localparam int unsigned ID_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned BC_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     full,
    output logic                     w_en,
    output logic [WIDTH-1:0]         data_in,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NUM_REQ*16-1:0]    stat_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StBurst} state_t;

    state_t           r_state;
    logic             r_grant_valid;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [BC_W-1:0]  r_beat_cnt;

    state_t           w_state_nxt;
    logic             w_grant_valid_nxt;
    logic [ID_W-1:0]  w_grant_id_nxt;
    logic [ID_W-1:0]  w_rr_ptr_nxt;
    logic [BC_W-1:0]  w_beat_cnt_nxt;

    logic             w_sel_found;
    logic [ID_W-1:0]  w_sel_id;
    logic             w_gnt_req_valid;
    logic [WIDTH-1:0] w_gnt_req_data;
    logic             w_accept;
    logic             w_last_beat;

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_sel_found && req_valid[(32'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_sel_found = 1'b1;
                w_sel_id    = ID_W'((32'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_gnt_req_valid = 1'b0;
        w_gnt_req_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_gnt_req_valid = req_valid[i];
                w_gnt_req_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset masks the beat so nothing reaches the FIFO while state is being cleared.
    assign w_accept    = r_grant_valid & w_gnt_req_valid & ~full & ~w_rst;
    assign w_last_beat = (r_beat_cnt == BC_W'(MAX_BURST - 1));

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (r_grant_id == ID_W'(i));
        end
    end

    assign w_en        = w_accept;
    assign data_in     = (r_grant_valid && !w_rst) ? w_gnt_req_data : '0;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_id_nxt    = r_grant_id;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_beat_cnt_nxt    = r_beat_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_sel_found) begin
                    w_state_nxt       = StBurst;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_id_nxt    = w_sel_id;
                    w_beat_cnt_nxt    = '0;
                end
            end
            StBurst: begin
                if (!w_gnt_req_valid || (w_accept && w_last_beat)) begin
                    w_state_nxt       = StIdle;
                    w_grant_valid_nxt = 1'b0;
                    w_rr_ptr_nxt      = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                         : r_grant_id + ID_W'(1);
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + BC_W'(1);
                end
            end
            default: begin
                w_state_nxt       = StIdle;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state       <= StIdle;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
        end
    end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    logic [15:0] r_stat_cnt [NUM_REQ];

    // Clear takes priority over a same-cycle beat; counters stick at all-ones.
    always_ff @(posedge w_clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_rst || stat_clr) begin
                r_stat_cnt[i] <= '0;
            end else if (req_ready[i] && (r_stat_cnt[i] != 16'hFFFF)) begin
                r_stat_cnt[i] <= r_stat_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_cnt[i*16 +: 16] = r_stat_cnt[i];
        end
    end
`else
    // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
// Statistics checks run only when ASYNC_FIFO_WR_ARB_STATS_EN is defined.
module tb_async_fifo_wr_arbiter;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        w_en;
    logic [7:0]  data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 w_clk = ~w_clk;

    async_fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) u_dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .full        (full),
        .w_en        (w_en),
        .data_in     (data_in),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_cnt    (stat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Check one cycle's outputs at the falling edge, then advance past the next rising edge.
    task automatic expect_cycle(input string tag, input logic gv, input logic [1:0] gid,
                                input logic wen, input logic [7:0] din);
        logic [3:0] exp_ready;
        @(negedge w_clk);
        exp_ready = wen ? (4'b0001 << gid) : 4'b0000;
        check({tag, ".grant_valid"}, 64'(grant_valid), 64'(gv));
        if (gv) check({tag, ".grant_id"}, 64'(grant_id), 64'(gid));
        check({tag, ".w_en"}, 64'(w_en), 64'(wen));
        check({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
        check({tag, ".data_in"}, 64'(data_in), 64'(din));
        tick();
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        req_data[idx*8 +: 8] = val;
    endtask

    task automatic pulse_reset();
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
    endtask

    initial begin
        w_rst     = 1'b1;
        req_valid = 4'hF;
        full      = 1'b0;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        tick();
        tick();

        // Reset with every requester asking: nothing leaks out.
        expect_cycle("rst_hold", 1'b0, 2'd0, 1'b0, 8'h00);
        w_rst = 1'b0;
        expect_cycle("rst_idle", 1'b0, 2'd0, 1'b0, 8'h00);
        expect_cycle("rst_gnt0", 1'b1, 2'd0, 1'b1, 8'hA0);
        // Reset mid-burst drops the beat even though the grant register is still set.
        w_rst = 1'b1;
        expect_cycle("rst_mid", 1'b1, 2'd0, 1'b0, 8'h00);
        w_rst = 1'b0;

        // Lone requester 2: two full bursts separated by one bubble.
        req_valid = 4'b0100;
        expect_cycle("single_arb", 1'b0, 2'd0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            set_data(2, 8'h10 + 8'(k));
            expect_cycle("single_a", 1'b1, 2'd2, 1'b1, 8'h10 + 8'(k));
        end
        expect_cycle("single_bubble", 1'b0, 2'd0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            set_data(2, 8'h14 + 8'(k));
            expect_cycle("single_b", 1'b1, 2'd2, 1'b1, 8'h14 + 8'(k));
        end
        req_valid = 4'b0000;
        expect_cycle("single_end", 1'b0, 2'd0, 1'b0, 8'h00);

        // All four requesting: order 0,1,2,3,0,1 with 4 beats and a bubble each.
        pulse_reset();
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'hF;
        for (int r = 0; r < 6; r++) begin
            expect_cycle("rot_bubble", 1'b0, 2'd0, 1'b0, 8'h00);
            for (int b = 0; b < 4; b++) begin
                expect_cycle("rot_beat", 1'b1, 2'(r % 4), 1'b1, 8'hA0 + 8'(r % 4));
            end
        end
        req_valid = 4'b0000;
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        @(negedge w_clk);
        check("stat_rot", stat_cnt, {16'd4, 16'd4, 16'd8, 16'd8});
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge w_clk);
        check("stat_clr", stat_cnt, 64'd0);
        tick();
`endif

        // Backpressure: full stalls requester 1 after two beats; two more beats then release.
        pulse_reset();
        req_valid = 4'b0010;
        expect_cycle("full_arb", 1'b0, 2'd0, 1'b0, 8'h00);
        expect_cycle("full_pre", 1'b1, 2'd1, 1'b1, 8'hA1);
        expect_cycle("full_pre", 1'b1, 2'd1, 1'b1, 8'hA1);
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_cycle("full_stall", 1'b1, 2'd1, 1'b0, 8'hA1);
        end
        full = 1'b0;
        expect_cycle("full_post", 1'b1, 2'd1, 1'b1, 8'hA1);
        expect_cycle("full_post", 1'b1, 2'd1, 1'b1, 8'hA1);
        expect_cycle("full_release", 1'b0, 2'd0, 1'b0, 8'h00);
        req_valid = 4'b0000;

        // Withdrawal by requester 3 with requester 0 waiting; pointer wraps to 0.
        pulse_reset();
        req_valid = 4'b1000;
        expect_cycle("wd_arb", 1'b0, 2'd0, 1'b0, 8'h00);
        req_valid = 4'b1001;
        expect_cycle("wd_beat", 1'b1, 2'd3, 1'b1, 8'hA3);
        req_valid = 4'b0001;
        expect_cycle("wd_drop", 1'b1, 2'd3, 1'b0, 8'hA3);
        expect_cycle("wd_bubble", 1'b0, 2'd0, 1'b0, 8'h00);
        expect_cycle("wd_gnt0", 1'b1, 2'd0, 1'b1, 8'hA0);
        req_valid = 4'b0000;

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        // Requester 0 alone for more than 65535 beats: its counter saturates.
        pulse_reset();
        req_valid = 4'b0001;
        repeat (82000) tick();
        req_valid = 4'b0000;
        @(negedge w_clk);
        check("stat_sat", stat_cnt, {16'd0, 16'd0, 16'd0, 16'hFFFF});
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
